// File: rtl/mmc1_host_seq.sv
// mmc1_host_seq: CPU-side command sequencer for the mmc1a serial port.
// Each queued command becomes one MMC1 write (shift reset, D7=1) or five
// serial writes (5-bit load, LSB first). The writes appear on the cartridge
// CPU bus, and every bus pin is driven from a register.
module mmc1_host_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_LEN     = 1,
    parameter int GAP_LEN    = 1
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CMD_VALID,
    output logic       CMD_RDY,
    input  logic       CMD_RST,
    input  logic [1:0] CMD_REG,
    input  logic [4:0] CMD_DATA,
    input  logic [2:0] PPUA_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       nROMSEL,
    output logic [2:0] PPUA,
    output logic       CPU_D0,
    output logic       CPU_D7,
    output logic       CPU_A13,
    output logic       CPU_A14,
    output logic       CPU_RnW
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 8;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

    // Command queue: entry = {rst, reg[1:0], data[4:0]}
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_work_rst;
    logic [1:0]    r_work_reg;
    logic [4:0]    r_work_data;
    logic          r_done_pend;

    logic          r_done;
    logic          r_busy;
    logic          r_nromsel;
    logic          r_rnw;
    logic          r_d0;
    logic          r_d7;
    logic          r_a13;
    logic          r_a14;
    logic [2:0]    r_ppua;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [AW:0]   w_count_next;
    logic          w_write_end;
    logic          w_gap_end;
    logic          w_last;
    logic          w_wr;
    logic [7:0]    w_data_ext;

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // The head is popped whenever the FSM idles with work queued. Popping frees
    // a slot in the same clock, so a full queue can still accept a push then.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign CMD_RDY = !w_full || w_pop;
    assign w_push  = CMD_VALID && CMD_RDY && !RES;
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    assign w_write_end = (r_cnt == CW'(WR_LEN - 1));
    assign w_gap_end   = (r_cnt == CW'(GAP_LEN - 1));
    assign w_last      = r_work_rst || (r_bit == 3'd4);
    assign w_wr        = (r_state == S_WRITE);
    assign w_data_ext  = {3'b000, r_work_data};

    // Queue storage: plain array written on push (no reset, RAM-friendly)
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {CMD_RST, CMD_REG, CMD_DATA};
        end
    end

    // Queue pointers and occupancy; reset drops everything queued
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Next-state decode for the write/gap sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty)   w_state_next = S_WRITE;
            S_WRITE: if (w_write_end) w_state_next = S_GAP;
            S_GAP:   if (w_gap_end)  w_state_next = w_last ? S_IDLE : S_WRITE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sequencer state plus registered bus pins. The pins follow the state one
    // clock later, so the first write shows one clock after the pop. DONE is
    // delayed the same way and so lands on the clock after the last bus gap.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_work_rst  <= 1'b0;
            r_work_reg  <= '0;
            r_work_data <= '0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_nromsel   <= 1'b1;
            r_rnw       <= 1'b1;
            r_d0        <= 1'b0;
            r_d7        <= 1'b0;
            r_a13       <= 1'b0;
            r_a14       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state || r_state == S_IDLE) r_cnt <= '0;
            else                                              r_cnt <= r_cnt + 1'b1;

            if (w_pop) begin
                {r_work_rst, r_work_reg, r_work_data} <= r_mem[r_rd_ptr];
                r_bit <= '0;
            end else if (r_state == S_GAP && w_gap_end && !w_last) begin
                r_bit <= r_bit + 1'b1;
            end

            r_done_pend <= (r_state == S_GAP) && w_gap_end && w_last;
            r_done      <= r_done_pend;
            r_busy      <= (w_state_next != S_IDLE) || (w_count_next != '0);

            r_nromsel <= !w_wr;
            r_rnw     <= !w_wr;
            r_d0      <= w_wr && !r_work_rst && w_data_ext[r_bit];
            r_d7      <= w_wr && r_work_rst;
            r_a13     <= w_wr && r_work_reg[0];
            r_a14     <= w_wr && r_work_reg[1];
        end
    end

    // PPU address pass-through, one register stage
    always_ff @(posedge CLK) begin
        if (RES) r_ppua <= '0;
        else     r_ppua <= PPUA_IN;
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign nROMSEL = r_nromsel;
    assign CPU_RnW = r_rnw;
    assign CPU_D0  = r_d0;
    assign CPU_D7  = r_d7;
    assign CPU_A13 = r_a13;
    assign CPU_A14 = r_a14;
    assign PPUA    = r_ppua;

endmodule

// File: tb/tb_mmc1_host_seq.sv
// tb_mmc1_host_seq: directed bench for mmc1_host_seq. Each command pushes its
// expected bus events (writes, then DONE) to a scoreboard queue. The monitor
// pops and compares one entry whenever a write or a DONE shows on the pins.
module tb_mmc1_host_seq;
    logic       CLK = 1'b0;
    logic       RES;
    logic       CMD_VALID;
    logic       CMD_RDY;
    logic       CMD_RST;
    logic [1:0] CMD_REG;
    logic [4:0] CMD_DATA;
    logic [2:0] PPUA_IN;
    logic       BUSY;
    logic       DONE;
    logic       nROMSEL;
    logic [2:0] PPUA;
    logic       CPU_D0;
    logic       CPU_D7;
    logic       CPU_A13;
    logic       CPU_A14;
    logic       CPU_RnW;

    mmc1_host_seq dut (
        .CLK(CLK), .RES(RES), .CMD_VALID(CMD_VALID), .CMD_RDY(CMD_RDY),
        .CMD_RST(CMD_RST), .CMD_REG(CMD_REG), .CMD_DATA(CMD_DATA),
        .PPUA_IN(PPUA_IN), .BUSY(BUSY), .DONE(DONE), .nROMSEL(nROMSEL),
        .PPUA(PPUA), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .CPU_A13(CPU_A13),
        .CPU_A14(CPU_A14), .CPU_RnW(CPU_RnW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_done = 0;
    int last_done_cyc = -1;
    int first_write_cyc = -1;
    bit saw_rdy_low = 1'b0;

    // event word: {DONE, D0, D7, A13, A14, RnW, nROMSEL}
    logic [6:0] sb[$];
    localparam logic [6:0] DONE_EV = 7'b1000011;

    function automatic logic [6:0] wr_ev(input logic d0, input logic d7, input logic [1:0] r);
        return {1'b0, d0, d7, r[0], r[1], 1'b0, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {DONE, CPU_D0, CPU_D7, CPU_A13, CPU_A14, CPU_RnW, nROMSEL};
        if (nROMSEL == 1'b0 || DONE == 1'b1) begin
            if (DONE) begin
                n_done++;
                last_done_cyc = cyc;
            end else begin
                n_writes++;
                if (first_write_cyc < 0) first_write_cyc = cyc;
            end
            checks++;
            if (sb.size() == 0) begin
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected cyc=%0d observed=%b expected=none", cyc, obs);
                end
            end else begin
                exp = sb.pop_front();
                assert (obs === exp) else begin
                    errors++;
                    $error("FAIL sb_event cyc=%0d observed=%b expected=%b", cyc, obs, exp);
                end
                $display("cyc=%0d event=%b", cyc, obs);
            end
        end else begin
            checks++;
            assert ({CPU_D0, CPU_D7, CPU_A13, CPU_A14, CPU_RnW} === 5'b00001) else begin
                errors++;
                $error("FAIL idle_bus cyc=%0d observed=%b expected=00001", cyc,
                       {CPU_D0, CPU_D7, CPU_A13, CPU_A14, CPU_RnW});
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        monitor();
    endtask

    // Offer one command, waiting for CMD_RDY; p = cycle index of the push edge
    task automatic push_cmd(input logic rst, input logic [1:0] r, input logic [4:0] d, output int p);
        int k;
        if (rst) begin
            sb.push_back(wr_ev(1'b0, 1'b1, r));
        end else begin
            for (int i = 0; i < 5; i++) sb.push_back(wr_ev(d[i], 1'b0, r));
        end
        sb.push_back(DONE_EV);
        CMD_VALID = 1'b1;
        CMD_RST   = rst;
        CMD_REG   = r;
        CMD_DATA  = d;
        k = 0;
        while (!CMD_RDY && k < 200) begin
            saw_rdy_low = 1'b1;
            step();
            k++;
        end
        check("rdy_timeout", 32'(CMD_RDY), 32'd1);
        step();
        p = cyc;
        CMD_VALID = 1'b0;
        $display("cyc=%0d push rst=%0d reg=%0d data=%b", p, rst, r, d);
    endtask

    task automatic wait_dones(input int target, input int bound);
        int k;
        k = 0;
        while (n_done < target && k < bound) begin
            step();
            k++;
        end
        check("done_timeout", 32'(n_done), 32'(target));
    endtask

    initial begin
        int p;
        int w0;
        int d0;
        RES = 1'b1;
        CMD_VALID = 1'b1;
        CMD_RST = 1'b0;
        CMD_REG = 2'd3;
        CMD_DATA = 5'h1f;
        PPUA_IN = 3'b101;

        // Reset held 3 clocks with a command offered: nothing may be queued
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outputs",
                  32'({nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14, PPUA, BUSY, DONE, CMD_RDY}),
                  32'(12'b1100_0000_0001));
        end
        RES = 1'b0;
        CMD_VALID = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("idle_after_reset_busy", 32'(BUSY), 32'd0);
        check("ppua_reg", 32'(PPUA), 32'(3'b101));
        PPUA_IN = 3'b010;
        check("ppua_hold", 32'(PPUA), 32'(3'b101));
        step();
        check("ppua_update", 32'(PPUA), 32'(3'b010));

        // Single load: REG=3 DATA=10110
        first_write_cyc = -1;
        w0 = n_writes;
        push_cmd(1'b0, 2'd3, 5'b10110, p);
        check("busy_after_push", 32'(BUSY), 32'd1);
        wait_dones(1, 40);
        check("load_first_write_lat", 32'(first_write_cyc - p), 32'd2);
        check("load_done_lat", 32'(last_done_cyc - p), 32'd12);
        check("load_write_count", 32'(n_writes - w0), 32'd5);
        step();
        check("load_busy_end", 32'(BUSY), 32'd0);

        // Shift-reset command to REG=1
        first_write_cyc = -1;
        w0 = n_writes;
        push_cmd(1'b1, 2'd1, 5'b11111, p);
        wait_dones(2, 20);
        check("rst_first_write_lat", 32'(first_write_cyc - p), 32'd2);
        check("rst_done_lat", 32'(last_done_cyc - p), 32'd4);
        check("rst_write_count", 32'(n_writes - w0), 32'd1);

        // One executing plus five back-to-back: queue fills, push+pop when full
        d0 = n_done;
        push_cmd(1'b0, 2'd2, 5'b01011, p);
        step();
        step();
        saw_rdy_low = 1'b0;
        push_cmd(1'b1, 2'd0, 5'b00000, p);
        push_cmd(1'b0, 2'd1, 5'b11001, p);
        push_cmd(1'b1, 2'd3, 5'b01010, p);
        push_cmd(1'b0, 2'd0, 5'b00111, p);
        check("queue_not_full_early", 32'(saw_rdy_low), 32'd0);
        push_cmd(1'b0, 2'd3, 5'b11110, p);
        check("rdy_low_when_full", 32'(saw_rdy_low), 32'd1);
        wait_dones(d0 + 6, 400);
        check("backlog_sb_drained", 32'(sb.size()), 32'd0);
        step();
        check("backlog_busy_end", 32'(BUSY), 32'd0);
        check("backlog_rdy_end", 32'(CMD_RDY), 32'd1);

        // Reset during the 3rd write of a load, with a second command queued
        d0 = n_done;
        w0 = n_writes;
        push_cmd(1'b0, 2'd3, 5'b10101, p);
        push_cmd(1'b1, 2'd2, 5'b00000, p);
        for (int k = 0; k < 40 && (n_writes - w0) < 3; k++) step();
        check("abort_reached_3rd_write", 32'(n_writes - w0), 32'd3);
        RES = 1'b1;
        sb.delete();
        step();
        check("abort_outputs",
              32'({nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14, BUSY, DONE, CMD_RDY}),
              32'(9'b11_0000_001));
        RES = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);

        // Fresh load after the abort runs all five bits from bit 0
        first_write_cyc = -1;
        w0 = n_writes;
        push_cmd(1'b0, 2'd1, 5'b00011, p);
        wait_dones(d0 + 1, 40);
        check("post_abort_first_write", 32'(first_write_cyc - p), 32'd2);
        check("post_abort_done_lat", 32'(last_done_cyc - p), 32'd12);
        check("post_abort_write_count", 32'(n_writes - w0), 32'd5);
        check("post_abort_sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
